// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) for the 24-bit RISC core; optional PERF_CNT_EN adds retire/stall counters.
// Latency: 3 cycles branch/jump, 4 R/imm/sw, 5 lw; pulses are Mealy on state, static controls register in DECODE.
// Backpressure: stalls in FETCH on imem_rdy, in MEM on dmem_rdy; MEM aborts after MEM_TIMEOUT cycles.
module mc_control_unit #(
    parameter int ALU_CNT_W   = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4+ALU_CNT_W-1:0] opcode,
    input  logic                   imem_rdy,
    input  logic                   dmem_rdy,
    input  logic                   alu_zero,
    output logic                   imem_req,
    output logic                   ir_wen,
    output logic                   pc_wen,
    output logic [1:0]             pc_cnt,
    output logic                   reg_src,
    output logic                   reg_wen,
    output logic                   alu_src,
    output logic                   w_src,
    output logic                   mem_req,
    output logic                   mem_wen,
    output logic                   check_immed,
    output logic [ALU_CNT_W-1:0]   alu_cnt,
    output logic                   busy,
    output logic                   mem_err
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]            instr_retired,
    output logic [31:0]            stall_cycles
`endif
);

    localparam int OP_W = 4 + ALU_CNT_W;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_RTYPE, C_IMM, C_BEQ, C_BNE, C_LW, C_SW, C_JUMP} cls_t;

    state_t          state, next_state;
    logic [OP_W-1:0] op_q;
    logic [TO_W-1:0] to_cnt;
    cls_t            cls, dec_cls;

    logic imem_req_c, ir_wen_c, pc_wen_c, reg_wen_c, mem_req_c, mem_wen_c, mem_err_c;
    logic [1:0] pc_cnt_c;

    function automatic cls_t classify(input logic [OP_W-1:0] op);
        cls_t c;
        if (op == '0) begin
            c = C_JUMP;
        end else begin
            unique case (op[3:2])
                2'b00, 2'b01: c = C_RTYPE;
                2'b10:        c = C_IMM;
                default: begin
                    unique case (op[1:0])
                        2'b00:   c = C_BEQ;
                        2'b01:   c = C_BNE;
                        2'b10:   c = C_LW;
                        default: c = C_SW;
                    endcase
                end
            endcase
        end
        return c;
    endfunction

    assign dec_cls = classify(opcode);
    assign cls     = classify(op_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_FETCH:  if (imem_rdy) next_state = S_DECODE;
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                unique case (cls)
                    C_RTYPE, C_IMM: next_state = S_WB;
                    C_LW, C_SW:     next_state = S_MEM;
                    default:        next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (dmem_rdy) begin
                    next_state = (cls == C_LW) ? S_WB : S_FETCH;
                end else if (to_cnt == TO_LAST) begin
                    next_state = S_FETCH;
                end
            end
            S_WB:     next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req_c = 1'b0;
        ir_wen_c   = 1'b0;
        pc_wen_c   = 1'b0;
        pc_cnt_c   = 2'b00;
        reg_wen_c  = 1'b0;
        mem_req_c  = 1'b0;
        mem_wen_c  = 1'b0;
        mem_err_c  = 1'b0;
        unique case (state)
            S_FETCH: begin
                imem_req_c = 1'b1;
                ir_wen_c   = imem_rdy;
            end
            S_EXEC: begin
                unique case (cls)
                    C_BEQ: begin
                        pc_wen_c = 1'b1;
                        pc_cnt_c = alu_zero ? 2'b01 : 2'b00;
                    end
                    C_BNE: begin
                        pc_wen_c = 1'b1;
                        pc_cnt_c = alu_zero ? 2'b00 : 2'b01;
                    end
                    C_JUMP: begin
                        pc_wen_c = 1'b1;
                        pc_cnt_c = 2'b10;
                    end
                    default: begin
                    end
                endcase
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_wen_c = (cls == C_SW);
                // Completion beats the timeout when both land in the same cycle.
                if (dmem_rdy) begin
                    pc_wen_c = (cls == C_SW);
                end else if (to_cnt == TO_LAST) begin
                    mem_err_c = 1'b1;
                    pc_wen_c  = 1'b1;
                end
            end
            S_WB: begin
                reg_wen_c = 1'b1;
                pc_wen_c  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Strobes are forced low while reset is held so nothing fires during reset.
    assign imem_req = rst_n & imem_req_c;
    assign ir_wen   = rst_n & ir_wen_c;
    assign pc_wen   = rst_n & pc_wen_c;
    assign pc_cnt   = rst_n ? pc_cnt_c : 2'b00;
    assign reg_wen  = rst_n & reg_wen_c;
    assign mem_req  = rst_n & mem_req_c;
    assign mem_wen  = rst_n & mem_wen_c;
    assign mem_err  = rst_n & mem_err_c;
    assign busy     = ~(rst_n & (state == S_FETCH) & ~imem_rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            reg_src     <= 1'b0;
            alu_src     <= 1'b0;
            w_src       <= 1'b0;
            check_immed <= 1'b0;
            alu_cnt     <= '0;
        end else if (state == S_DECODE) begin
            op_q        <= opcode;
            reg_src     <= (dec_cls == C_RTYPE);
            alu_src     <= (dec_cls == C_IMM) || (dec_cls == C_LW) || (dec_cls == C_SW);
            w_src       <= (dec_cls == C_LW);
            check_immed <= (dec_cls == C_IMM);
            alu_cnt     <= opcode[OP_W-1:4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == S_EXEC) begin
            to_cnt <= '0;
        end else if (state == S_MEM && !dmem_rdy) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_retired <= '0;
            stall_cycles  <= '0;
        end else begin
            if (pc_wen_c) begin
                instr_retired <= instr_retired + 32'd1;
            end
            if ((state == S_FETCH && !imem_rdy) || (state == S_MEM && !dmem_rdy)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle control unit for the 24-bit RISC core. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- It latches the opcode once per instruction and drives registered datapath enables.
- It handshakes with instruction and data memory through ready inputs, and times out on a hung data memory.
- Sits between the instruction register and the datapath (regfile, ALU muxes, PC logic, data memory).

Parameters:
- ALU_CNT_W, 2: width of the ALU-op field. Opcode width is 4+ALU_CNT_W; the ALU-op field is opcode[4+ALU_CNT_W-1:4].
- MEM_TIMEOUT, 15: maximum number of MEM-state cycles to wait for dmem_rdy before aborting (minimum 1).
- TO_W, 4: timeout counter width. Must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  4+ALU_CNT_W  opcode field from the instruction register.
- imem_rdy  in  1  instruction word valid this cycle.
- dmem_rdy  in  1  data memory access complete this cycle.
- alu_zero  in  1  ALU zero flag.
- imem_req  out  1  instruction fetch request.
- ir_wen  out  1  instruction register load.
- pc_wen  out  1  PC update.
- pc_cnt  out  2  PC source: 00 = +1, 01 = branch, 10 = jump.
- reg_src  out  1  regfile destination select (1 = rd, R-type).
- reg_wen  out  1  regfile write.
- alu_src  out  1  ALU operand B: 1 = immediate.
- w_src  out  1  writeback source: 1 = memory.
- mem_req  out  1  data memory request.
- mem_wen  out  1  data memory write.
- check_immed  out  1  immediate-format flag.
- alu_cnt  out  ALU_CNT_W  ALU operation.
- busy  out  1  low only in FETCH while imem_rdy is low.
- mem_err  out  1  one-cycle pulse on data memory timeout.

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to FETCH; latched opcode, timeout counter and every output go to 0.
  - Exception: busy reads 1 in FETCH during reset (combinational on state).
  - Reset asserted mid-instruction abandons it; no partial regfile or memory write may follow.
- Decode on opcode[3:0], latched in DECODE:
  - 0–7: R-type.
  - 8–11: immediate ALU ops.
  - 12: beq.
  - 13: bne.
  - 14: lw.
  - 15: sw.
  - An all-zero opcode is JUMP and takes precedence over R-type.
- Static controls are registered in DECODE and held until the next DECODE:
  - R-type: reg_src=1, reg_wen-class.
  - Immediate: alu_src=1, check_immed=1.
  - lw: alu_src=1, w_src=1.
  - sw: alu_src=1.
  - alu_cnt = latched upper opcode bits.
- FETCH:
  - imem_req=1.
  - On imem_rdy: ir_wen pulses for 1 cycle, then go to DECODE.
- DECODE: 1 cycle; latch opcode and controls, then go to EXEC. Opcode changes after DECODE are ignored.
- EXEC:
  - R/imm → WB.
  - lw/sw → MEM; timeout counter cleared.
  - beq: pc_wen=1, pc_cnt = alu_zero ? 01 : 00, → FETCH.
  - bne: same, with alu_zero inverted.
  - JUMP: pc_wen=1, pc_cnt=10, → FETCH.
- MEM:
  - mem_req=1; mem_wen=1 for sw, held for the whole MEM stay.
  - On dmem_rdy:
    - lw → WB.
    - sw → pc_wen=1, pc_cnt=00, → FETCH.
  - Timeout counter increments each MEM cycle without dmem_rdy. On reaching MEM_TIMEOUT with no dmem_rdy:
    - mem_err pulses; pc_wen=1, pc_cnt=00 (skip instruction); → FETCH; no regfile write.
  - dmem_rdy in the same cycle as the timeout: the completion wins and there is no mem_err.
- WB: reg_wen=1 for 1 cycle, pc_wen=1, pc_cnt=00, → FETCH.
- Cycle counts with imem_rdy and dmem_rdy immediate:
  - R/imm: 4.
  - Branch/jump: 3.
  - sw: 4.
  - lw: 5.
- Pulse outputs (ir_wen, pc_wen, reg_wen, mem_err) are single-cycle per instruction. pc_cnt is 00 whenever pc_wen=0.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined:
  - Adds outputs instr_retired [31:0] and stall_cycles [31:0], both reset to 0.
  - instr_retired increments on every pc_wen, including the timeout skip.
  - stall_cycles increments each FETCH cycle with imem_rdy=0 and each MEM cycle with dmem_rdy=0.
  - Both counters wrap at 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then opcode 6'b01_0011, imem_rdy=1 → ir_wen at cycle 1, reg_src=1, alu_cnt=01, reg_wen+pc_wen (pc_cnt=00) at cycle 4.
- beq (6'h0C) with alu_zero=1 → pc_wen with pc_cnt=01 in EXEC (cycle 3), no reg_wen. Same with alu_zero=0 → pc_cnt=00. bne with alu_zero=0 → pc_cnt=01.
- lw (6'h0E), dmem_rdy delayed 3 cycles → mem_req held 4 cycles, w_src=1, reg_wen in WB at cycle 8.
- sw (6'h0F), dmem_rdy never → mem_wen held 15 cycles, mem_err 1-cycle pulse, pc_cnt=00, no reg_wen, return to FETCH. With dmem_rdy on the 15th cycle → no mem_err.
- Opcode 6'h00 → pc_cnt=10 with pc_wen in EXEC. rst_n low mid-MEM of sw → mem_wen and mem_req drop immediately; next fetch begins after release.
- PERF_CNT_EN: 3 R-type instructions plus 2 imem stall cycles → instr_retired=3, stall_cycles=2.
